// File: rtl/fifo_stream_reader_if.sv
// Stream reader bus: sync_fifo read side plus
// the valid/ready output stream.
interface fifo_stream_reader_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_dout;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a burst of words from a sync_fifo into
// a valid/ready stream through a 2-entry skid buffer.
module fifo_stream_reader #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_W-1:0]     burst_len,
    fifo_stream_reader_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          words_sent
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] buf0_q, buf0_d;
    logic [DATA_W-1:0] buf1_q, buf1_d;
    logic [15:0]       sent_q, sent_d;
    logic              pop;
    logic              rd_en;
    logic              last_rd;
    logic [1:0]        credit;

    assign pop = (count_q != 2'd0) & bus.m_ready;

    // Read issue: the entry leaving this cycle frees its slot,
    // which is what lets a full-rate stream sustain one word
    // per cycle without ever exceeding two words of storage.
    always_comb begin
        credit  = count_q + {1'b0, inflight_q}
                - {1'b0, pop};
        rd_en   = (state_q == RUN) && !bus.fifo_empty
               && (issued_q < len_q) && (credit < 2'd2);
        last_rd = rd_en && (issued_q + LEN_W'(1) == len_q);
    end

    // Burst FSM and read counters.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q;
        inflight_d = rd_en;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d    = burst_len;
                    issued_d = '0;
                    if (burst_len != '0) state_d = RUN;
                    else                 state_d = DONE;
                end
            end
            RUN: begin
                if (rd_en) issued_d = issued_q + LEN_W'(1);
                if (last_rd) state_d = DRAIN;
            end
            DRAIN: begin
                if (!inflight_q && count_q == 2'd0)
                    state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Skid buffer: pop the head first, then append the capture.
    always_comb begin
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        count_d = count_q;
        sent_d  = sent_q;
        if (pop) begin
            buf0_d  = buf1_q;
            count_d = count_q - 2'd1;
            sent_d  = sent_q + 16'd1;
        end
        if (inflight_q) begin
            if (count_d == 2'd0) buf0_d = bus.fifo_dout;
            else                 buf1_d = bus.fifo_dout;
            count_d = count_d + 2'd1;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            sent_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            sent_q     <= sent_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (count_q != 2'd0);
    assign bus.m_data     = buf0_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign words_sent     = sent_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a
// behavioural sync_fifo and stream monitor.
module tb_fifo_stream_reader;
    localparam int DW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] burst_len;
    logic          busy;
    logic          done;
    logic [15:0]   words_sent;

    fifo_stream_reader_if #(.DATA_W(DW)) bus ();

    fifo_stream_reader #(
        .DATA_W(DW),
        .LEN_W (LW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .burst_len (burst_len),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    // Behavioural sync_fifo: registered read data.
    logic [DW-1:0] mem [256];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    logic flush = 1'b0;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (bus.fifo_rd_en && !bus.fifo_empty) begin
            bus.fifo_dout <= mem[rd_ptr[7:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Stream / strobe monitor.
    logic          mon_clr = 1'b0;
    int            rd_cnt, done_cnt, rd_empty, valid_cnt;
    int            unstable;
    logic [DW-1:0] outs [$];
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data;

    always @(posedge clk) begin
        if (mon_clr) begin
            rd_cnt    <= 0;
            done_cnt  <= 0;
            rd_empty  <= 0;
            valid_cnt <= 0;
            unstable  <= 0;
            outs.delete();
        end else begin
            if (bus.fifo_rd_en) rd_cnt <= rd_cnt + 1;
            if (bus.fifo_rd_en && bus.fifo_empty)
                rd_empty <= rd_empty + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (bus.m_valid) valid_cnt <= valid_cnt + 1;
            if (prev_hold && bus.m_valid
                && bus.m_data !== prev_data)
                unstable <= unstable + 1;
            if (bus.m_valid && bus.m_ready)
                outs.push_back(bus.m_data);
        end
        prev_hold <= bus.m_valid && !bus.m_ready && reset;
        prev_data <= bus.m_data;
    end

    int checks   = 0;
    int failures = 0;
    int ws_exp   = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d",
                     nm, act, exp);
        end
    endtask

    task automatic push(input int v);
        mem[wr_ptr[7:0]] = DW'(v);
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic fill(input int first, input int n);
        for (int i = 0; i < n; i++) push(first + i);
    endtask

    task automatic clr();
        mon_clr = 1'b1;
        flush   = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic go(input int len);
        start     = 1'b1;
        burst_len = LW'(len);
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input bit tog);
        int n = 0;
        while ((done_cnt == 0 || busy) && n < 300) begin
            if (tog) bus.m_ready = ~bus.m_ready;
            @(negedge clk);
            n++;
        end
        bus.m_ready = 1'b1;
        chk({nm, "_timeout"}, (n >= 300), 0);
    endtask

    task automatic chk_seq(input string nm,
                           input int first, input int n);
        int bad = 0;
        chk({nm, "_nout"}, outs.size(), n);
        for (int i = 0; i < n && i < outs.size(); i++)
            if (outs[i] !== DW'(first + i)) bad++;
        chk({nm, "_order"}, bad, 0);
    endtask

    typedef struct {
        int fill;
        int len;
        bit tog;
        int exp_reads;
        int exp_left;
    } vec_t;

    vec_t tbl [4];

    initial begin
        tbl[0] = '{fill: 8, len: 8, tog: 0,
                   exp_reads: 8, exp_left: 0};
        tbl[1] = '{fill: 8, len: 3, tog: 0,
                   exp_reads: 3, exp_left: 5};
        tbl[2] = '{fill: 6, len: 5, tog: 1,
                   exp_reads: 5, exp_left: 1};
        tbl[3] = '{fill: 3, len: 1, tog: 0,
                   exp_reads: 1, exp_left: 2};

        reset       = 1'b0;
        start       = 1'b0;
        burst_len   = '0;
        bus.m_ready = 1'b1;
        clr();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_rd_en", bus.fifo_rd_en, 0);
        chk("rst_data", bus.m_data, 0);
        chk("rst_words", words_sent, 0);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven bursts.
        for (int v = 0; v < 4; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            clr();
            fill(1, tbl[v].fill);
            go(tbl[v].len);
            wait_idle(nm, tbl[v].tog);
            ws_exp += tbl[v].len;
            chk({nm, "_reads"}, rd_cnt, tbl[v].exp_reads);
            chk({nm, "_dones"}, done_cnt, 1);
            chk_seq(nm, 1, tbl[v].len);
            chk({nm, "_words"}, words_sent, ws_exp);
            chk({nm, "_left"}, wr_ptr - rd_ptr,
                tbl[v].exp_left);
            chk({nm, "_unstable"}, unstable, 0);
        end

        // First-word latency and full-rate throughput.
        clr();
        fill(1, 4);
        go(4);
        chk("lat_rd_en", bus.fifo_rd_en, 1);
        chk("lat_busy", busy, 1);
        chk("lat_v0", bus.m_valid, 0);
        @(negedge clk);
        chk("lat_v1", bus.m_valid, 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("thr_v%0d", i), bus.m_valid, 1);
            chk($sformatf("thr_d%0d", i), bus.m_data, i);
        end
        wait_idle("thr", 0);
        ws_exp += 4;
        chk("thr_words", words_sent, ws_exp);

        // Downstream stall holds the head word.
        clr();
        fill(1, 4);
        bus.m_ready = 1'b0;
        go(4);
        begin
            int n = 0;
            while (!bus.m_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("stall_timeout", (n >= 50), 0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall_d%0d", i), bus.m_data, 1);
        end
        chk("stall_reads", rd_cnt, 2);
        bus.m_ready = 1'b1;
        wait_idle("stall", 0);
        ws_exp += 4;
        chk_seq("stall", 1, 4);
        chk("stall_unstable", unstable, 0);

        // Empty FIFO stalls reads until data arrives.
        clr();
        go(2);
        repeat (5) @(negedge clk);
        chk("empty_reads", rd_cnt, 0);
        chk("empty_busy", busy, 1);
        push(7);
        repeat (10) @(negedge clk);
        push(9);
        wait_idle("empty", 0);
        ws_exp += 2;
        chk("empty_nout", outs.size(), 2);
        chk("empty_w0", outs[0], 7);
        chk("empty_w1", outs[1], 9);
        chk("empty_rd_cnt", rd_cnt, 2);
        chk("empty_rd_bad", rd_empty, 0);
        chk("empty_dones", done_cnt, 1);

        // Zero-length burst; start while busy ignored.
        clr();
        fill(1, 3);
        start     = 1'b1;
        burst_len = '0;
        @(negedge clk);
        burst_len = LW'(3);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 1);
        @(negedge clk);
        start = 1'b0;
        chk("zero_done_end", done, 0);
        chk("zero_idle", busy, 0);
        repeat (3) @(negedge clk);
        chk("zero_idle2", busy, 0);
        chk("zero_reads", rd_cnt, 0);
        chk("zero_valid", valid_cnt, 0);
        chk("zero_dones", done_cnt, 1);
        chk("zero_words", words_sent, ws_exp);

        // Asynchronous reset mid-burst.
        clr();
        fill(1, 8);
        go(8);
        begin
            int n = 0;
            while (outs.size() < 2 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("rstmb_timeout", (n >= 50), 0);
        end
        reset = 1'b0;
        #1;
        chk("rstmb_valid", bus.m_valid, 0);
        chk("rstmb_rd_en", bus.fifo_rd_en, 0);
        chk("rstmb_busy", busy, 0);
        chk("rstmb_done", done, 0);
        chk("rstmb_data", bus.m_data, 0);
        chk("rstmb_words", words_sent, 0);
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        ws_exp = 0;
        @(negedge clk);
        clr();
        fill(1, 3);
        go(3);
        wait_idle("post", 0);
        ws_exp += 3;
        chk_seq("post", 1, 3);
        chk("post_words", words_sent, ws_exp);
        chk("post_dones", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data word width; must match the attached sync_fifo.
REQ-002 SHALL have parameter LEN_W, default 8, meaning burst-length field width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-low (0 = in reset).
REQ-005 SHALL have port start  input  1  one-cycle burst request, sampled only in IDLE.
REQ-006 SHALL have port burst_len  input  LEN_W  number of words to drain, sampled with start.
REQ-007 SHALL have port fifo_empty  input  1  empty flag from sync_fifo.
REQ-008 SHALL have port fifo_rd_en  output  1  read strobe to sync_fifo read_en.
REQ-009 SHALL have port fifo_dout  input  DATA_W  sync_fifo data_out, valid the cycle after the edge that sampled fifo_rd_en=1.
REQ-010 SHALL have port m_valid  output  1  output word valid.
REQ-011 SHALL have port m_ready  input  1  downstream accept; transfer = m_valid & m_ready at rising edge.
REQ-012 SHALL have port m_data  output  DATA_W  output word.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-015 SHALL have port words_sent  output  16  running count of output transfers.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: start=1 with burst_len!=0 SHALL load remaining=burst_len and go to RUN; start=1 with burst_len==0 SHALL go directly to DONE.
REQ-018 start SHALL be ignored in any state other than IDLE.
REQ-019 RUN: fifo_rd_en SHALL assert (combinationally) iff fifo_empty=0, issued<burst_len, and buffered words + in-flight reads < 2.
REQ-020 fifo_rd_en SHALL never assert while fifo_empty=1 or outside RUN.
REQ-021 RUN SHALL go to DRAIN on the edge where the final read of the burst is issued.
REQ-022 DRAIN SHALL go to DONE when no read is in flight, the buffer is empty, and the last word has transferred.
REQ-023 DONE SHALL hold done=1 for exactly one cycle, then return to IDLE.
REQ-024 Each fifo_dout word SHALL be captured into a 2-entry skid buffer one cycle after its read edge.
REQ-025 m_valid SHALL be high whenever the buffer is non-empty; m_data SHALL be the oldest entry.
REQ-026 m_data SHALL remain stable while m_valid=1 and m_ready=0.
REQ-027 Words SHALL be delivered in FIFO order, with no loss or duplication.
REQ-028 Buffer overflow SHALL be impossible: in-flight reads + occupancy never exceed 2.
REQ-029 First-word latency: with FIFO non-empty, start sampled at edge 0 -> fifo_rd_en high in cycle after edge 0, capture at edge 2, m_valid high after edge 2.
REQ-030 With m_ready held at 1 and FIFO non-empty, throughput SHALL be one word per cycle.
REQ-031 A simultaneous capture and output transfer SHALL leave occupancy unchanged.
REQ-032 words_sent SHALL increment on each transfer and wrap 0xFFFF->0x0000; it is not cleared by start.
REQ-033 An empty FIFO during RUN SHALL stall reads with no timeout; reading resumes when fifo_empty falls.

Reset
REQ-034 reset=0 SHALL immediately and asynchronously force: state IDLE, buffer empty, in-flight cleared, fifo_rd_en=0, m_valid=0, m_data=0, busy=0, done=0, words_sent=0.
REQ-035 Reset asserted mid-burst SHALL discard buffered and in-flight words; the new burst starts only with a new start after reset release.

Verification
REQ-036 FIFO holds 1..8, start burst_len=8, m_ready=1 -> exactly 8 fifo_rd_en cycles; m_data 1..8 on consecutive cycles; one done pulse; words_sent=8.
REQ-037 FIFO holds 1..8, burst_len=3 -> output 1,2,3 only; exactly 3 reads; FIFO left with 4..8 (empty=0).
REQ-038 burst_len=4, m_ready=0 for 5 cycles after the first word -> m_data holds 1; at most 2 reads outstanding; then 1,2,3,4 delivered intact.
REQ-039 FIFO empty, start burst_len=2, writer pushes 7 then 9 ten cycles later -> no fifo_rd_en while empty; output 7,9; done afterward.
REQ-040 burst_len=0 start -> DONE next cycle, done pulse, no fifo_rd_en, no m_valid; start during busy ignored.
REQ-041 reset driven low mid-burst after 2 transfers -> all outputs zero immediately, words_sent=0; a new burst after release works normally.
